// File: rtl/bf1_skid_pipe_reg.sv
// ID/EX pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Carries operands, specifiers, next-PC and WB/M/EX control; flush inserts a bubble; stall cycles are counted.
module bf1_skid_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int PC_W    = 8,
    parameter int WB_W    = 2,
    parameter int M_W     = 3,
    parameter int ALUOP_W = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_BF1,
    input  logic                 rst_BF1,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic [DATA_W-1:0]    data1_in,
    input  logic [DATA_W-1:0]    data2_in,
    input  logic [DATA_W-1:0]    imm_in,
    input  logic [REG_W-1:0]     rd_in,
    input  logic [REG_W-1:0]     rt_in,
    input  logic [PC_W-1:0]      pc_in,
    input  logic [WB_W-1:0]      wb_in,
    input  logic [M_W-1:0]       m_in,
    input  logic [ALUOP_W+1:0]   ex_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    data1_out,
    output logic [DATA_W-1:0]    data2_out,
    output logic [DATA_W-1:0]    imm_out,
    output logic [REG_W-1:0]     rd_out,
    output logic [REG_W-1:0]     rt_out,
    output logic [PC_W-1:0]      pc_out,
    output logic [WB_W-1:0]      wb_out,
    output logic [M_W-1:0]       m_out,
    output logic                 reg_dst,
    output logic [ALUOP_W-1:0]   alu_op,
    output logic                 alu_src,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int EX_W = ALUOP_W + 2;
    localparam int E_W  = 3*DATA_W + 2*REG_W + PC_W + WB_W + M_W + EX_W;

    logic [E_W-1:0]   main_reg;
    logic [E_W-1:0]   skid_reg;
    logic             main_v_reg;
    logic             skid_v_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [E_W-1:0]   in_word;
    logic [WB_W-1:0]  wb_raw;
    logic [M_W-1:0]   m_raw;
    logic [EX_W-1:0]  ex_raw;
    logic             accept;
    logic             drain;

    assign in_word = {data1_in, data2_in, imm_in, rd_in, rt_in, pc_in, wb_in, m_in, ex_in};
    assign {data1_out, data2_out, imm_out, rd_out, rt_out, pc_out, wb_raw, m_raw, ex_raw} = main_reg;

    assign in_ready  = !skid_v_reg;
    assign out_valid = main_v_reg;
    assign stall_cnt = stall_cnt_reg;
    assign accept    = in_valid && in_ready;
    assign drain     = main_v_reg && out_ready;

    // Control groups are gated so a bubble can never write back or touch memory.
    assign wb_out  = main_v_reg ? wb_raw : '0;
    assign m_out   = main_v_reg ? m_raw  : '0;
    assign reg_dst = main_v_reg && ex_raw[ALUOP_W+1];
    assign alu_op  = main_v_reg ? ex_raw[ALUOP_W:1] : '0;
    assign alu_src = main_v_reg && ex_raw[0];

    always_ff @(posedge clk_BF1) begin
        if (rst_BF1) begin
            main_reg      <= '0;
            skid_reg      <= '0;
            main_v_reg    <= 1'b0;
            skid_v_reg    <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            if (main_v_reg && !out_ready && stall_cnt_reg != {CNT_W{1'b1}})
                stall_cnt_reg <= stall_cnt_reg + 1'b1;

            if (flush) begin
                main_v_reg <= 1'b0;
                skid_v_reg <= 1'b0;
            end else if (!main_v_reg || (drain && !skid_v_reg)) begin
                main_v_reg <= accept;
                if (accept)
                    main_reg <= in_word;
            end else if (drain) begin
                // Skid is full here, so in_ready was low and no accept can coincide.
                main_reg   <= skid_reg;
                main_v_reg <= 1'b1;
                skid_v_reg <= accept;
                if (accept)
                    skid_reg <= in_word;
            end else if (accept) begin
                skid_reg   <= in_word;
                skid_v_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bf1_skid_pipe_reg.sv
// Directed bench for bf1_skid_pipe_reg: streaming, skid stall, flush, control decode, counter saturation, reset.
module tb_bf1_skid_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int PC_W    = 8;
    localparam int WB_W    = 2;
    localparam int M_W     = 3;
    localparam int ALUOP_W = 2;
    localparam int CNT_W   = 3;

    logic                clk_BF1 = 1'b0;
    logic                rst_BF1;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [DATA_W-1:0]   data1_in, data2_in, imm_in;
    logic [REG_W-1:0]    rd_in, rt_in;
    logic [PC_W-1:0]     pc_in;
    logic [WB_W-1:0]     wb_in;
    logic [M_W-1:0]      m_in;
    logic [ALUOP_W+1:0]  ex_in;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   data1_out, data2_out, imm_out;
    logic [REG_W-1:0]    rd_out, rt_out;
    logic [PC_W-1:0]     pc_out;
    logic [WB_W-1:0]     wb_out;
    logic [M_W-1:0]      m_out;
    logic                reg_dst;
    logic [ALUOP_W-1:0]  alu_op;
    logic                alu_src;
    logic [CNT_W-1:0]    stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    bf1_skid_pipe_reg #(
        .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W), .WB_W(WB_W),
        .M_W(M_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clk_BF1(clk_BF1), .rst_BF1(rst_BF1),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .data1_in(data1_in), .data2_in(data2_in), .imm_in(imm_in),
        .rd_in(rd_in), .rt_in(rt_in), .pc_in(pc_in),
        .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data1_out(data1_out), .data2_out(data2_out), .imm_out(imm_out),
        .rd_out(rd_out), .rt_out(rt_out), .pc_out(pc_out),
        .wb_out(wb_out), .m_out(m_out),
        .reg_dst(reg_dst), .alu_op(alu_op), .alu_src(alu_src),
        .stall_cnt(stall_cnt)
    );

    always #5 clk_BF1 = ~clk_BF1;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_BF1);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [DATA_W-1:0] d1, input logic [WB_W-1:0] wb,
                          input logic [M_W-1:0] m, input logic [ALUOP_W+1:0] ex);
        in_valid = v;
        data1_in = d1;
        data2_in = d1 + 32'd100;
        imm_in   = d1 + 32'd200;
        rd_in    = d1[REG_W-1:0];
        rt_in    = d1[REG_W-1:0] + 5'd1;
        pc_in    = d1[PC_W-1:0] + 8'd4;
        wb_in    = wb;
        m_in     = m;
        ex_in    = ex;
    endtask

    task automatic do_reset();
        rst_BF1 = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 2'd0, 3'd0, 4'd0);
        step();
        step();
        rst_BF1 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        vectors++;
        if (stall_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        vectors++;
        if (data1_out !== 32'd0 || wb_out !== 2'd0 || m_out !== 3'd0)
            begin miscompares++; $display("FAIL reset_fields got d1=%0h wb=%0b m=%0b want 0", data1_out, wb_out, m_out); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 32'(i), 2'd1, 3'd2, 4'd3);
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
            if (i == 1) begin
                vectors++;
                if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_pre_valid got %0b want 0", out_valid); end
            end
            step();
            vectors++;
            if (out_valid !== 1'b1 || data1_out !== 32'(i))
                begin miscompares++; $display("FAIL stream_out[%0d] got v=%0b d1=%0d want v=1 d1=%0d", i, out_valid, data1_out, i); end
        end
        vectors++;
        if (data2_out !== 32'd104 || imm_out !== 32'd204 || rd_out !== 5'd4 || rt_out !== 5'd5 || pc_out !== 8'd8)
            begin miscompares++; $display("FAIL stream_fields got d2=%0d imm=%0d rd=%0d rt=%0d pc=%0d want 104 204 4 5 8",
                                          data2_out, imm_out, rd_out, rt_out, pc_out); end
        set_in(1'b0, 32'd0, 2'd0, 3'd0, 4'd0);
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drained got %0b want 0", out_valid); end
    endtask

    task automatic test_skid_stall();
        logic [DATA_W-1:0] exp_d1 [3];
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'd10, 2'd1, 3'd1, 4'd1);
        step();
        set_in(1'b1, 32'd11, 2'd1, 3'd1, 4'd1);
        step();
        vectors++;
        if (in_ready !== 1'b0 || data1_out !== 32'd10 || stall_cnt !== 3'd1)
            begin miscompares++; $display("FAIL skid_fill got rdy=%0b d1=%0d cnt=%0d want 0 10 1", in_ready, data1_out, stall_cnt); end
        set_in(1'b1, 32'd12, 2'd1, 3'd1, 4'd1);
        step();
        vectors++;
        if (in_ready !== 1'b0 || data1_out !== 32'd10 || out_valid !== 1'b1 || stall_cnt !== 3'd2)
            begin miscompares++; $display("FAIL skid_hold got rdy=%0b v=%0b d1=%0d cnt=%0d want 0 1 10 2", in_ready, out_valid, data1_out, stall_cnt); end
        out_ready = 1'b1;
        exp_d1[0] = 32'd11;
        exp_d1[1] = 32'd12;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || data1_out !== exp_d1[i])
                begin miscompares++; $display("FAIL skid_order[%0d] got v=%0b d1=%0d want v=1 d1=%0d", i, out_valid, data1_out, exp_d1[i]); end
        end
        set_in(1'b0, 32'd0, 2'd0, 3'd0, 4'd0);
        step();
        vectors++;
        if (out_valid !== 1'b0 || stall_cnt !== 3'd2)
            begin miscompares++; $display("FAIL skid_end got v=%0b cnt=%0d want 0 2", out_valid, stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'd20, 2'b11, 3'b111, 4'b1111);
        step();
        set_in(1'b1, 32'd21, 2'b11, 3'b111, 4'b1111);
        step();
        set_in(1'b1, 32'd99, 2'b11, 3'b111, 4'b1111);
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin miscompares++; $display("FAIL flush_state got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
        vectors++;
        if (wb_out !== 2'd0 || m_out !== 3'd0 || reg_dst !== 1'b0 || alu_op !== 2'd0 || alu_src !== 1'b0)
            begin miscompares++; $display("FAIL flush_ctrl got wb=%0b m=%0b rd=%0b op=%0b src=%0b want 0", wb_out, m_out, reg_dst, alu_op, alu_src); end
        vectors++;
        if (stall_cnt !== 3'd2) begin miscompares++; $display("FAIL flush_cnt got %0d want 2", stall_cnt); end
        // Accept offered alongside flush while in_ready=1 must be dropped.
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 32'd0, 2'd0, 3'd0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_d[%0d] got v=%0b d1=%0d want v=0", i, out_valid, data1_out); end
            step();
        end
    endtask

    task automatic test_ctrl_map();
        do_reset();
        out_ready = 1'b1;
        set_in(1'b1, 32'd30, 2'b10, 3'b101, 4'b1011);
        step();
        vectors++;
        if (reg_dst !== 1'b1 || alu_op !== 2'b01 || alu_src !== 1'b1 || wb_out !== 2'b10 || m_out !== 3'b101)
            begin miscompares++; $display("FAIL ctrl_a got rd=%0b op=%0b src=%0b wb=%0b m=%0b want 1 01 1 10 101", reg_dst, alu_op, alu_src, wb_out, m_out); end
        set_in(1'b1, 32'd31, 2'b01, 3'b010, 4'b0110);
        step();
        vectors++;
        if (reg_dst !== 1'b0 || alu_op !== 2'b11 || alu_src !== 1'b0 || wb_out !== 2'b01 || m_out !== 3'b010)
            begin miscompares++; $display("FAIL ctrl_b got rd=%0b op=%0b src=%0b wb=%0b m=%0b want 0 11 0 01 010", reg_dst, alu_op, alu_src, wb_out, m_out); end
        set_in(1'b0, 32'd0, 2'd0, 3'd0, 4'd0);
        step();
        vectors++;
        if (wb_out !== 2'd0 || m_out !== 3'd0 || reg_dst !== 1'b0 || alu_op !== 2'd0 || alu_src !== 1'b0 || out_valid !== 1'b0)
            begin miscompares++; $display("FAIL ctrl_bubble got v=%0b wb=%0b m=%0b op=%0b want all 0", out_valid, wb_out, m_out, alu_op); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'd40, 2'd0, 3'd0, 4'd0);
        step();
        set_in(1'b0, 32'd0, 2'd0, 3'd0, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_cnt = (i > 7) ? 3'd7 : 3'(i);
            vectors++;
            if (stall_cnt !== exp_cnt) begin miscompares++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, stall_cnt, exp_cnt); end
        end
        rst_BF1 = 1'b1;
        step();
        rst_BF1 = 1'b0;
        vectors++;
        if (stall_cnt !== 3'd0) begin miscompares++; $display("FAIL sat_reset got %0d want 0", stall_cnt); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'd50, 2'b11, 3'b111, 4'b1111);
        step();
        set_in(1'b1, 32'd51, 2'b11, 3'b111, 4'b1111);
        step();
        set_in(1'b1, 32'd77, 2'b11, 3'b111, 4'b1111);
        rst_BF1 = 1'b1;
        flush = 1'b1;
        step();
        rst_BF1 = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 32'd0, 2'd0, 3'd0, 4'd0);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 3'd0)
            begin miscompares++; $display("FAIL midrst_state got v=%0b rdy=%0b cnt=%0d want 0 1 0", out_valid, in_ready, stall_cnt); end
        vectors++;
        if (data1_out !== 32'd0 || data2_out !== 32'd0 || imm_out !== 32'd0 || rd_out !== 5'd0 || rt_out !== 5'd0 || pc_out !== 8'd0)
            begin miscompares++; $display("FAIL midrst_data got d1=%0d d2=%0d imm=%0d rd=%0d rt=%0d pc=%0d want 0", data1_out, data2_out, imm_out, rd_out, rt_out, pc_out); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_leak[%0d] got v=%0b d1=%0d want v=0", i, out_valid, data1_out); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid_stall();
        test_flush();
        test_ctrl_map();
        test_saturation();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bf1_skid_pipe_reg.md
Name: bf1_skid_pipe_reg

Overview:
Parametrised ID/EX pipeline register, the successor of the fixed-width BF1 stage. It carries operands, immediate/funct, rd/rt, next-PC and WB/M/EX control from decode to execute. A valid/ready handshake with a one-entry skid buffer lets execute stall without breaking the 1-per-cycle throughput. Flush inserts a bubble for branch and hazard recovery. A saturating counter records stall cycles.

Parameters:
DATA_W, 32, width of data1/data2/imm fields
REG_W, 5, width of rd/rt register specifiers
PC_W, 8, width of next-instruction field
WB_W, 2, width of WB control group
M_W, 3, width of M control group
ALUOP_W, 1, width of ALUOp; the EX group is ALUOP_W+2 bits
CNT_W, 16, width of stall counter

Ports:
clk_BF1  in  1  clock; all state updates on the rising edge
rst_BF1  in  1  synchronous reset, active-high
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept this cycle
flush  in  1  kill all held entries this cycle
data1_in, data2_in, imm_in  in  DATA_W each  operands and sign-extended immediate/funct
rd_in, rt_in  in  REG_W each  destination candidates
pc_in  in  PC_W  next-instruction address
wb_in  in  WB_W  WB control
m_in  in  M_W  M control
ex_in  in  ALUOP_W+2  {RegDst, ALUOp[ALUOP_W-1:0], ALUSrc}
out_valid  out  1  execute-side entry valid
out_ready  in  1  execute consumes this cycle
data1_out, data2_out, imm_out  out  DATA_W each
rd_out, rt_out  out  REG_W each
pc_out  out  PC_W
wb_out  out  WB_W
m_out  out  M_W
reg_dst  out  1
alu_op  out  ALUOP_W
alu_src  out  1
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- State: main entry (drives outputs) with main_v; skid entry with skid_v. Both entries hold all fields.
- in_ready is registered and equals !skid_v. Accept happens on in_valid && in_ready. Drain happens on out_valid && out_ready.
- Reset (rst_BF1=1 at the edge): main_v=0, skid_v=0, all data/field registers=0, stall_cnt=0, so in_ready=1 on the next cycle. Inputs are ignored in any cycle with rst_BF1=1. Reset mid-stall drops both entries.
- Latency: an accept into the empty stage gives out_valid=1 on the next cycle with the fields captured. Throughput is 1 per cycle while out_ready=1.
- Per-edge update when not in reset or flush:
  - main empty, or main draining with skid empty: an accept loads main.
  - main draining with skid full: skid moves to main; an accept in the same cycle loads skid.
  - main held (out_valid && !out_ready): an accept loads skid. in_ready was 1, so skid was empty.
- Ordering is strictly FIFO. No entry is duplicated or lost.
- Output stability: while out_valid && !out_ready, every output holds its value.
- Bubble gating: wb_out, m_out, reg_dst, alu_op and alu_src are forced to 0 whenever out_valid=0. Data outputs are don't-care when out_valid=0 and hold their last value.
- ex_in decode: reg_dst = ex_in[ALUOP_W+1], alu_op = ex_in[ALUOP_W:1], alu_src = ex_in[0].
- flush=1: main_v=0 and skid_v=0 at the edge. A simultaneous accept is discarded. A simultaneous drain completes normally for the consumer, since it sampled the entry this cycle. Next cycle: out_valid=0, control outputs 0, in_ready=1. rst_BF1 has priority over flush.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready and saturates at 2^CNT_W-1. It is not cleared by flush; only reset clears it.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 for 4 cycles with data1_in=1,2,3,4 and out_ready=1 -> out_valid first high 1 cycle after the first accept, data1_out=1,2,3,4 on consecutive cycles, in_ready=1 throughout.
- Stall with skid: out_ready=0 while sending A, B, C back to back -> A held on outputs, B taken into skid, in_ready=0 and C not accepted. out_ready=1 -> A, B, C emerge in order. stall_cnt equals the stalled cycle count.
- Flush mid-stall: main=A, skid=B, flush=1 with in_valid=1 (D) -> next cycle out_valid=0, wb_out=m_out=0, reg_dst=alu_op=alu_src=0, in_ready=1. D is never output.
- Control mapping with ALUOP_W=2: ex_in=4'b1011, wb_in=2'b10, m_in=3'b101 -> reg_dst=1, alu_op=2'b01, alu_src=1, wb_out=2'b10, m_out=3'b101.
- Counter saturation with CNT_W=3: out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays at 7. A following rst_BF1 returns it to 0.
- Reset mid-operation: both entries full, rst_BF1=1 with in_valid=1 -> next cycle out_valid=0, all outputs 0, in_ready=1, and nothing from before the reset is output.
